controller_poll_scheduler: RTL and testbench
============================================

// Module: controller_poll_scheduler
// PURPOSE
//  Sequences the serial controller interface: issues one start_fetch per frame (or on CPU request),
//  waits a fixed number of enabled cycles for the shift to finish, then snapshots all pads.
//  Publishes current button state plus sticky "pressed since last read" bits to the CPU register
//  file, and flags polls missed because a trigger arrived while a fetch was in flight.
// PARAMETERS
//  NUM_CONTROLLERS  2   number of pads; matches the controller interface instance
//  FETCH_CYCLES     16  enabled cycles from start_fetch to capture; must be >= 14, the interface's worst-case fetch latency
// PORTS
//  clk_in           in   1     system clock; all logic on posedge
//  rst_B            in   1     reset, asynchronous, active-low
//  clk_in_enable    in   1     clock enable; state advances only when high
//  frame_tick       in   1     one-enabled-cycle pulse at vblank start
//  auto_en          in   1     1: frame_tick triggers a poll; 0: frame_tick ignored
//  poll_req         in   1     CPU one-shot poll request, honoured regardless of auto_en
//  ack_read         in   1     CPU read strobe; clears buttons_pressed and missed_tick
//  start_fetch      out  1     to controller interface; high for exactly one enabled cycle
//  buttons_in       in   8*N   controller_buttons_out_LIST from the interface, 8 bits per pad
//  buttons_cur      out  8*N   latest captured (optionally debounced) state, 1 = held
//  buttons_pressed  out  8*N   sticky 0->1 transitions of buttons_cur since last ack_read
//  sample_valid     out  1     one-enabled-cycle pulse when buttons_cur updates
//  busy             out  1     high from START through CAPTURE inclusive
//  poll_count       out  8     completed polls, wraps 255->0
//  missed_tick      out  1     sticky: trigger arrived while busy
// BEHAVIOUR
//  Reset: every output 0, state IDLE, wait counter 0; reset mid-fetch aborts immediately, no capture.
//  trigger = poll_req | (frame_tick & auto_en), evaluated only when clk_in_enable.
//  FSM (transitions only on enabled cycles):
//   IDLE    : trigger -> START.
//   START   : start_fetch=1 this cycle; load counter=FETCH_CYCLES-1 -> WAIT.
//   WAIT    : counter decrements; at 0 -> CAPTURE.
//   CAPTURE : register buttons_in into snapshot; update buttons_cur/buttons_pressed;
//             sample_valid=1; poll_count+=1 (mod 256) -> IDLE.
//  Latency: trigger cycle T -> start_fetch at T+1 -> sample_valid at T+1+FETCH_CYCLES.
//  busy=1 in START/WAIT/CAPTURE; a trigger there is dropped and sets missed_tick.
//  frame_tick and poll_req in the same cycle produce one poll.
//  buttons_pressed[i] |= buttons_cur_new[i] & ~buttons_cur_old[i] at CAPTURE.
//  ack_read clears buttons_pressed/missed_tick; if ack_read coincides with CAPTURE or a missed
//   trigger, the new set wins (bit ends 1), the old content is cleared.
//  clk_in_enable low: all state, counters and outputs hold; pulses stretch, not repeat.
//  poll_count wraps silently; no overflow flag.
// CONFIGURATION
//  CONTROLLER_POLL_DEBOUNCE_EN defined: keep previous raw snapshot; buttons_cur bit changes only when
//   two consecutive captures agree on the new value, otherwise holds. sample_valid still pulses each
//   CAPTURE. First poll after reset cannot change buttons_cur (raw history reset to 0).
//  Not defined: buttons_cur = raw capture every CAPTURE; no history register.
// TESTING
//  1 rst_B low mid-WAIT -> all outputs 0 asynchronously; release, no sample_valid until a new trigger.
//  2 auto_en=1, frame_tick at T, buttons_in=16'hA501 -> start_fetch at T+1, sample_valid at T+17,
//    buttons_cur=16'hA501, buttons_pressed=16'hA501, poll_count=1.
//  3 auto_en=0, frame_tick -> no start_fetch; poll_req -> poll runs; both same cycle -> exactly one poll.
//  4 frame_tick at T+5 during busy -> no second start_fetch, missed_tick=1; ack_read -> missed_tick=0.
//  5 buttons_in 8'h00->8'h03->8'h01 over 3 polls, ack_read coincident with 2nd CAPTURE ->
//    buttons_pressed=8'h03 after it; 3rd poll leaves it 8'h03 (no new 0->1 edges).
//  6 DEBOUNCE_EN: raw 8'h01,8'h00,8'h01,8'h01 -> buttons_cur 0,0,0,8'h01; without macro 1,0,1,1.
//  7 clk_in_enable toggled 50% during poll -> identical results, latency in enabled cycles unchanged.
//  8 257 polls -> poll_count=1.

Source files
------------

// File: rtl/controller_poll_scheduler.sv
// Controller poll scheduler: triggers a serial pad fetch, waits out the shift, snapshots the pads.
// Optional two-capture debounce of buttons_cur when CONTROLLER_POLL_DEBOUNCE_EN is defined.
module controller_poll_scheduler #(
  parameter int unsigned NUM_CONTROLLERS = 2,
  parameter int unsigned FETCH_CYCLES    = 16
) (
  input  logic                         clk_in,
  input  logic                         rst_B,
  input  logic                         clk_in_enable,
  input  logic                         frame_tick,
  input  logic                         auto_en,
  input  logic                         poll_req,
  input  logic                         ack_read,
  output logic                         start_fetch,
  input  logic [8*NUM_CONTROLLERS-1:0] buttons_in,
  output logic [8*NUM_CONTROLLERS-1:0] buttons_cur,
  output logic [8*NUM_CONTROLLERS-1:0] buttons_pressed,
  output logic                         sample_valid,
  output logic                         busy,
  output logic [7:0]                   poll_count,
  output logic                         missed_tick
);

  localparam int unsigned BW = 8 * NUM_CONTROLLERS;
  localparam int unsigned CW = (FETCH_CYCLES > 1) ? $clog2(FETCH_CYCLES) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_WAIT,
    S_CAPTURE
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [BW-1:0]   cur_q, cur_d;
  logic [BW-1:0]   pressed_q, pressed_d;
  logic [BW-1:0]   cur_new;
  logic [BW-1:0]   rise;
  logic [7:0]      count_q, count_d;
  logic            missed_q, missed_d;
  logic            trigger;
  logic            capture;
`ifdef CONTROLLER_POLL_DEBOUNCE_EN
  logic [BW-1:0]   hist_q, hist_d;
  logic [BW-1:0]   agree;
`endif

  assign trigger = clk_in_enable & (poll_req | (frame_tick & auto_en));
  assign capture = (state_q == S_CAPTURE);

  always_ff @(posedge clk_in or negedge rst_B) begin : state_reg
    if (!rst_B) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else if (clk_in_enable) begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin : next_state
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (trigger) state_d = S_START;
      end
      S_START: begin
        cnt_d   = CW'(FETCH_CYCLES - 1);
        state_d = S_WAIT;
      end
      S_WAIT: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_d == '0) state_d = S_CAPTURE;
      end
      S_CAPTURE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin : capture_value
`ifdef CONTROLLER_POLL_DEBOUNCE_EN
    // A bit follows the raw pad only once two consecutive captures agree on it.
    agree   = ~(buttons_in ^ hist_q);
    cur_new = (agree & buttons_in) | (~agree & cur_q);
    hist_d  = capture ? buttons_in : hist_q;
`else
    cur_new = buttons_in;
`endif
  end

  always_comb begin : datapath
    rise      = cur_new & ~cur_q;
    cur_d     = capture ? cur_new : cur_q;
    pressed_d = (ack_read ? '0 : pressed_q) | (capture ? rise : '0);
    count_d   = capture ? count_q + 8'd1 : count_q;
    missed_d  = (ack_read ? 1'b0 : missed_q) | (trigger & (state_q != S_IDLE));
  end

  always_ff @(posedge clk_in or negedge rst_B) begin : data_reg
    if (!rst_B) begin
      cur_q     <= '0;
      pressed_q <= '0;
      count_q   <= '0;
      missed_q  <= 1'b0;
`ifdef CONTROLLER_POLL_DEBOUNCE_EN
      hist_q    <= '0;
`endif
    end else if (clk_in_enable) begin
      cur_q     <= cur_d;
      pressed_q <= pressed_d;
      count_q   <= count_d;
      missed_q  <= missed_d;
`ifdef CONTROLLER_POLL_DEBOUNCE_EN
      hist_q    <= hist_d;
`endif
    end
  end

  // During CAPTURE the new values are presented alongside sample_valid and commit on the enabled edge.
  always_comb begin : outputs
    start_fetch     = (state_q == S_START);
    busy            = (state_q != S_IDLE);
    sample_valid    = capture;
    buttons_cur     = cur_d;
    buttons_pressed = capture ? pressed_d : pressed_q;
    poll_count      = count_d;
    missed_tick     = missed_q;
  end

endmodule

// File: tb/tb_controller_poll_scheduler.sv
// Scoreboard bench for controller_poll_scheduler: randomized polls against a transaction-level model.
module tb_controller_poll_scheduler;

  localparam int unsigned N = 2;
  localparam int unsigned W = 8 * N;

  logic         clk_in = 1'b0;
  logic         rst_B = 1'b0;
  logic         clk_in_enable = 1'b1;
  logic         frame_tick = 1'b0;
  logic         auto_en = 1'b0;
  logic         poll_req = 1'b0;
  logic         ack_read = 1'b0;
  logic [W-1:0] buttons_in = '0;
  logic         start_fetch;
  logic [W-1:0] buttons_cur;
  logic [W-1:0] buttons_pressed;
  logic         sample_valid;
  logic         busy;
  logic [7:0]   poll_count;
  logic         missed_tick;

  controller_poll_scheduler #(
    .NUM_CONTROLLERS(N),
    .FETCH_CYCLES(16)
  ) dut (
    .clk_in(clk_in),
    .rst_B(rst_B),
    .clk_in_enable(clk_in_enable),
    .frame_tick(frame_tick),
    .auto_en(auto_en),
    .poll_req(poll_req),
    .ack_read(ack_read),
    .start_fetch(start_fetch),
    .buttons_in(buttons_in),
    .buttons_cur(buttons_cur),
    .buttons_pressed(buttons_pressed),
    .sample_valid(sample_valid),
    .busy(busy),
    .poll_count(poll_count),
    .missed_tick(missed_tick)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic [W-1:0] cur;
    logic [W-1:0] pressed;
    logic [7:0]   cnt;
    int unsigned  cyc;
  } exp_t;

  exp_t        sb[$];
  int unsigned sq[$];
  int          compared = 0;
  int          mismatched = 0;
  int unsigned ecyc = 0;
  bit          toggle_en = 1'b0;

  logic [W-1:0] m_cur, m_pressed, m_hist;
  logic [7:0]   m_cnt;
  bit           m_missed;

  always @(posedge clk_in) if (clk_in_enable) ecyc <= ecyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  exp_t        mon_e;
  int unsigned mon_s;
  always @(negedge clk_in) begin
    if (rst_B === 1'b1 && clk_in_enable === 1'b1) begin
      if (start_fetch) begin
        if (sq.size() == 0) check("start_fetch_unexpected", 32'(start_fetch), 32'd0);
        else begin
          mon_s = sq.pop_front();
          check("start_fetch_cycle", ecyc, mon_s);
        end
      end
      if (sample_valid) begin
        if (sb.size() == 0) check("sample_valid_unexpected", 32'(sample_valid), 32'd0);
        else begin
          mon_e = sb.pop_front();
          check("sample_cycle", ecyc, mon_e.cyc);
          check("buttons_cur", 32'(buttons_cur), 32'(mon_e.cur));
          check("buttons_pressed", 32'(buttons_pressed), 32'(mon_e.pressed));
          check("poll_count", 32'(poll_count), 32'(mon_e.cnt));
        end
      end
    end
  end

  task automatic en_cycle();
    bit was;
    do begin
      @(posedge clk_in);
      was = clk_in_enable;
      #1;
      clk_in_enable = toggle_en ? 1'($urandom_range(0, 1)) : 1'b1;
    end while (!was);
  endtask

  task automatic model_reset();
    m_cur = '0; m_pressed = '0; m_hist = '0; m_cnt = '0; m_missed = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_start_fetch"}, 32'(start_fetch), 32'd0);
    check({tag, "_sample_valid"}, 32'(sample_valid), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_cur"}, 32'(buttons_cur), 32'd0);
    check({tag, "_pressed"}, 32'(buttons_pressed), 32'd0);
    check({tag, "_count"}, 32'(poll_count), 32'd0);
    check({tag, "_missed"}, 32'(missed_tick), 32'd0);
  endtask

  task automatic do_reset(input string tag);
    poll_req = 1'b0; frame_tick = 1'b0; ack_read = 1'b0;
    #2 rst_B = 1'b0;
    #1 check_all_zero(tag);
    model_reset();
    sb.delete();
    sq.delete();
    @(posedge clk_in); @(posedge clk_in); #1;
    rst_B = 1'b1;
  endtask

  // One poll transaction; extra (1..16) injects a frame_tick that many enabled cycles into the busy window.
  task automatic poll(input logic [W-1:0] raw, input bit req, input bit tick,
                      input bit ack_cap, input int unsigned extra);
    exp_t         e;
    int unsigned  t;
    logic [W-1:0] nc;
    buttons_in = raw;
    poll_req   = req;
    frame_tick = tick;
    t = ecyc;
`ifdef CONTROLLER_POLL_DEBOUNCE_EN
    nc = m_cur;
    for (int b = 0; b < int'(W); b++) if (raw[b] == m_hist[b]) nc[b] = raw[b];
    m_hist = raw;
`else
    nc = raw;
`endif
    m_pressed = (ack_cap ? '0 : m_pressed) | (nc & ~m_cur);
    m_cur = nc;
    m_cnt = m_cnt + 8'd1;
    e.cur = m_cur; e.pressed = m_pressed; e.cnt = m_cnt; e.cyc = t + 17;
    sq.push_back(t + 1);
    sb.push_back(e);
    en_cycle();
    poll_req = 1'b0;
    frame_tick = 1'b0;
    while (ecyc != t + 17) begin
      if (extra != 0 && ecyc == t + extra) begin
        frame_tick = 1'b1;
        en_cycle();
        frame_tick = 1'b0;
        if (auto_en) m_missed = 1'b1;
      end else en_cycle();
    end
    ack_read = ack_cap;
    en_cycle();
    ack_read = 1'b0;
    if (ack_cap) m_missed = 1'b0;
  endtask

  task automatic ack_idle();
    ack_read = 1'b1;
    en_cycle();
    ack_read = 1'b0;
    m_pressed = '0;
    m_missed = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    repeat (3) @(posedge clk_in);
    #1 check_all_zero("por");
    rst_B = 1'b1;
    en_cycle();

    // Frame-tick driven poll.
    auto_en = 1'b1;
    poll(16'hA501, 1'b0, 1'b1, 1'b0, 0);

    // Reset during WAIT aborts the poll; nothing may follow.
    buttons_in = 16'h00FF;
    poll_req = 1'b1;
    sq.push_back(ecyc + 1);
    en_cycle();
    poll_req = 1'b0;
    repeat (5) en_cycle();
    check("busy_mid_wait", 32'(busy), 32'd1);
    do_reset("rst_mid_wait");
    repeat (25) en_cycle();
    check("post_reset_busy", 32'(busy), 32'd0);

    // auto_en=0 ignores frame_tick; poll_req still works; both together give one poll.
    auto_en = 1'b0;
    frame_tick = 1'b1;
    en_cycle();
    frame_tick = 1'b0;
    repeat (20) en_cycle();
    check("ignored_tick_count", 32'(poll_count), 32'(m_cnt));
    poll(16'h1234, 1'b1, 1'b0, 1'b0, 0);
    auto_en = 1'b1;
    poll(16'h5678, 1'b1, 1'b1, 1'b0, 0);
    repeat (3) en_cycle();

    // Tick while busy is dropped and flagged.
    poll(16'h0F0F, 1'b0, 1'b1, 1'b0, 5);
    check("missed_set", 32'(missed_tick), 32'(m_missed));
    ack_idle();
    check("missed_cleared", 32'(missed_tick), 32'd0);
    check("pressed_cleared", 32'(buttons_pressed), 32'd0);

    // Sticky pressed bits with ack coincident with capture.
    poll(16'h0000, 1'b1, 1'b0, 1'b0, 0);
    poll(16'h0003, 1'b1, 1'b0, 1'b1, 0);
    check("pressed_after_ack_capture", 32'(buttons_pressed), 32'(m_pressed));
    poll(16'h0001, 1'b1, 1'b0, 1'b0, 0);
    check("pressed_third_poll", 32'(buttons_pressed), 32'(m_pressed));

    // Raw 01,00,01,01 from reset.
    en_cycle();
    do_reset("rst_seq");
    en_cycle();
    poll(16'h0001, 1'b1, 1'b0, 1'b0, 0);
    poll(16'h0000, 1'b1, 1'b0, 1'b0, 0);
    poll(16'h0001, 1'b1, 1'b0, 1'b0, 0);
    poll(16'h0001, 1'b1, 1'b0, 1'b0, 0);

    // Randomized polls; first half with a gated clock enable; total crosses the 8-bit wrap.
    for (int i = 0; i < 260; i++) begin
      logic [W-1:0] raw;
      bit req, tick, ack;
      int unsigned extra;
      toggle_en = (i < 130);
      raw = W'($urandom);
      req = 1'($urandom_range(0, 1));
      tick = 1'($urandom_range(0, 1));
      auto_en = 1'($urandom_range(0, 1));
      if (!(req | (tick & auto_en))) req = 1'b1;
      ack = ($urandom_range(0, 3) == 0);
      extra = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 16) : 0;
      poll(raw, req, tick, ack, extra);
      if ((i % 8) == 0) check("rand_missed", 32'(missed_tick), 32'(m_missed));
      if ($urandom_range(0, 9) == 0) ack_idle();
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 4)) en_cycle();
    end
    toggle_en = 1'b0;
    repeat (30) en_cycle();
    check("final_poll_count", 32'(poll_count), 32'(m_cnt));
    check("final_missed", 32'(missed_tick), 32'(m_missed));
    check("sb_drained", 32'(sb.size()), 32'd0);
    check("start_q_drained", 32'(sq.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
